// File: rtl/i2s_tdm_tx.sv
// ---------------------------------------------------------------------------
// i2s_tdm_tx -- I2S/TDM playback serializer for the codec path.
//
// Whole audio frames (one sample per channel) arrive on a valid/ready
// stream. They are buffered in a frame FIFO and serialized MSB first.
// The block generates bit clock, frame clock and serial data toward the
// codec. When the FIFO runs dry at a frame boundary, a silent (all-zero)
// frame is sent and the sticky underflow flag is raised.
//
// Optional feature (compile-time macro I2S_TDM_TX_UNDERFLOW_CNT_EN):
//   adds the 16-bit saturating output underflow_cnt, which counts
//   underflow loads.
//
// Ports
//   s00_axi_aclk     in   block clock
//   s00_axi_aresetn  in   asynchronous active-low reset
//   en               in   serializer enable (0 = IDLE, 1 = RUN)
//   s_tdata          in   frame, channel c at [c*DATA_W +: DATA_W]
//   s_tvalid         in   frame valid
//   s_tready         out  FIFO not full (registered)
//   fifo_level       out  frames currently stored
//   underflow        out  sticky: a frame slot was served with no data
//   underflow_clr    in   clears underflow (a same-cycle set wins)
//   underflow_cnt    out  [15:0] underflow load count (macro only)
//   bclk             out  bit clock
//   lrclk            out  frame/word clock, I2S one-bit early
//   pbdat            out  serial playback data, MSB first
// ---------------------------------------------------------------------------
module i2s_tdm_tx #(
  parameter int DATA_W     = 24,
  parameter int SLOT_W     = 32,
  parameter int NUM_CH     = 2,
  parameter int BCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                             s00_axi_aclk,
  input  logic                             s00_axi_aresetn,
  input  logic                             en,
  input  logic [NUM_CH*DATA_W-1:0]         s_tdata,
  input  logic                             s_tvalid,
  output logic                             s_tready,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
  output logic                             underflow,
  input  logic                             underflow_clr,
`ifdef I2S_TDM_TX_UNDERFLOW_CNT_EN
  output logic [15:0]                      underflow_cnt,
`endif
  output logic                             bclk,
  output logic                             lrclk,
  output logic                             pbdat
);

  localparam int FRAME_W    = NUM_CH * DATA_W;
  localparam int FRAME_BITS = NUM_CH * SLOT_W;
  localparam int HALF       = FRAME_BITS / 2;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int LVL_W      = PTR_W + 1;
  localparam int DIV_W      = $clog2(BCLK_DIV);
  localparam int CH_W       = $clog2(NUM_CH);
  localparam int POS_W      = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Serial data bit for slot s, position p of a frame. Bits past the
  // sample width pad the slot with zeros.
  function automatic logic frame_bit(input logic [FRAME_W-1:0] f,
                                     input logic [CH_W-1:0]    s,
                                     input logic [POS_W-1:0]   p);
    logic [FRAME_W-1:0] sh;
    int                 idx;
    if (int'(p) >= DATA_W) return 1'b0;
    idx = int'(s) * DATA_W + (DATA_W - 1 - int'(p));
    sh  = f >> idx;
    return sh[0];
  endfunction

  // Frame clock level for the bit at slot s, position p. It leads the
  // first-half and second-half MSBs by one bit (I2S delay).
  function automatic logic lr_at(input logic [CH_W-1:0]  s,
                                 input logic [POS_W-1:0] p);
    int b;
    b = int'(s) * SLOT_W + int'(p);
    return (b >= HALF - 1) && (b <= FRAME_BITS - 2);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t               state, state_next;
  logic [DIV_W-1:0]     div;
  logic [CH_W-1:0]      slot, nxt_slot;
  logic [POS_W-1:0]     pos, nxt_pos;
  logic                 tick, fall, last_bit, load;

  logic [FRAME_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [LVL_W-1:0]     level_next;
  logic                 push, pop, fifo_empty;
  logic [FRAME_W-1:0]   ld_frame;
  logic [FRAME_W-1:0]   frame_p0;
  logic                 uf_set;

  // ---- FIFO control -------------------------------------------------------
  assign fifo_empty = (fifo_level == '0);
  assign push       = s_tvalid && s_tready;
  assign pop        = load && !fifo_empty;
  assign uf_set     = load && fifo_empty;
  assign ld_frame   = fifo_empty ? '0 : mem[rd_ptr];

  always_comb begin
    level_next = fifo_level;
    case ({push, pop})
      2'b10:   level_next = fifo_level + LVL_W'(1);
      2'b01:   level_next = fifo_level - LVL_W'(1);
      default: level_next = fifo_level;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      s_tready   <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_level <= level_next;
      s_tready   <= (level_next != LVL_W'(FIFO_DEPTH));
    end
  end

  // ---- FIFO storage / frame register (data, no reset) ---------------------
  always_ff @(posedge s00_axi_aclk) begin
    if (push) mem[wr_ptr] <= s_tdata;
    if (load) frame_p0    <= ld_frame;
  end

  // ---- Sequencer ------------------------------------------------------------
  always_comb begin
    nxt_pos  = pos + POS_W'(1);
    nxt_slot = slot;
    if (pos == POS_W'(SLOT_W - 1)) begin
      nxt_pos  = '0;
      nxt_slot = slot + CH_W'(1);
    end
  end

  assign last_bit = (slot == CH_W'(NUM_CH - 1)) && (pos == POS_W'(SLOT_W - 1));

  always_comb begin
    state_next = state;
    tick       = 1'b0;
    fall       = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        if (!en) begin
          state_next = IDLE;
        end else begin
          tick = (div == DIV_W'(BCLK_DIV - 1));
          fall = tick && bclk;
          load = fall && last_bit;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) state <= IDLE;
    else                  state <= state_next;
  end

  // ---- Bit clock, bit index and serial outputs ----------------------------
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      div   <= '0;
      slot  <= '0;
      pos   <= '0;
      bclk  <= 1'b0;
      lrclk <= 1'b0;
      pbdat <= 1'b0;
    end else if (state_next == IDLE) begin
      // Leaving RUN drops the partial frame at this very edge.
      div   <= '0;
      slot  <= '0;
      pos   <= '0;
      bclk  <= 1'b0;
      lrclk <= 1'b0;
      pbdat <= 1'b0;
    end else if (load) begin
      // Frame start: MSB of channel 0 appears right after the load edge.
      div   <= '0;
      slot  <= '0;
      pos   <= '0;
      bclk  <= 1'b0;
      lrclk <= lr_at('0, '0);
      pbdat <= ld_frame[DATA_W-1];
    end else if (tick) begin
      div  <= '0;
      bclk <= ~bclk;
      if (fall) begin
        slot  <= nxt_slot;
        pos   <= nxt_pos;
        pbdat <= frame_bit(frame_p0, nxt_slot, nxt_pos);
        lrclk <= lr_at(nxt_slot, nxt_pos);
      end
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // ---- Underflow reporting --------------------------------------------------
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn)   underflow <= 1'b0;
    else if (uf_set)        underflow <= 1'b1;
    else if (underflow_clr) underflow <= 1'b0;
  end

`ifdef I2S_TDM_TX_UNDERFLOW_CNT_EN
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      underflow_cnt <= '0;
    end else if (uf_set) begin
      // A clear in the same cycle restarts the count at this event.
      underflow_cnt <= underflow_clr ? 16'd1 : sat_inc16(underflow_cnt);
    end else if (underflow_clr) begin
      underflow_cnt <= '0;
    end
  end
`endif

endmodule
